// File: rtl/polar_pkg.sv
// polar_pkg: shared defaults, FSM state type and index helpers for the polar encoder.
package polar_pkg;
  localparam int N_DEF = 8;
  localparam int LOG2N_DEF = 3;
  localparam int K_DEF = 4;
  localparam logic [N_DEF-1:0] FROZEN_DEF = 8'h17;
  typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;
  function automatic int bitrev(input int idx, input int log2n);
    int r;
    r = 0;
    for (int b = 0; b < log2n; b++) r = (r << 1) | ((idx >> b) & 1);
    return r;
  endfunction
  function automatic int info_count(input logic [63:0] mask, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) c += mask[i] ? 0 : 1;
    return c;
  endfunction
  function automatic int info_index(input int k, input logic [63:0] mask = 64'(FROZEN_DEF), input int n = N_DEF);
    int c;
    int r;
    c = 0;
    r = 0;
    for (int i = 0; i < n; i++)
      if (!mask[i]) begin
        if (c == k) r = i;
        c++;
      end
    return r;
  endfunction
endpackage

// File: rtl/polar_xor_stage.sv
// polar_xor_stage: one runtime-selected butterfly stage, v[i] ^= v[i+2^s] where bit s of i is clear.
module polar_xor_stage #(
  parameter int N = 8,
  parameter int LOG2N = 3
) (
  input  logic [N-1:0]     i_v_in,
  input  logic [LOG2N-1:0] i_stage,
  output logic [N-1:0]     o_v_out
);
  for (genvar i = 0; i < N; i++) begin : g_bit
    logic [LOG2N-1:0] w_hit;
    for (genvar j = 0; j < LOG2N; j++) begin : g_st
      if (((i >> j) & 1) != 0) begin : g_hi
        assign w_hit[j] = 1'b0;
      end else begin : g_lo
        assign w_hit[j] = (i_stage == LOG2N'(j)) && i_v_in[i + (1 << j)];
      end
    end
    assign o_v_out[i] = i_v_in[i] ^ (|w_hit);
  end
endmodule

// File: rtl/polar_encoder_seq.sv
// polar_encoder_seq: sequential polar encoder, one butterfly stage per clock, valid/ready on both sides.
// Optional POLAR_BITREV_EN presents the codeword in bit-reversed order (pure output wiring).
module polar_encoder_seq
  import polar_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int LOG2N = LOG2N_DEF,
  parameter int K = K_DEF,
  parameter logic [N-1:0] FROZEN_MASK = FROZEN_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_msg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_code,
  output logic         busy
);
  if (info_count(64'(FROZEN_MASK), N) != K) begin : g_bad_k
    $error("K must equal the number of zeros in FROZEN_MASK");
  end
  state_t r_state, w_next;
  logic [LOG2N-1:0] r_cnt;
  logic [N-1:0] r_v, w_load, w_stage;
  for (genvar i = 0; i < N; i++) begin : g_frz
    if (FROZEN_MASK[i]) begin : g_z
      assign w_load[i] = 1'b0;
    end
  end
  for (genvar k = 0; k < K; k++) begin : g_info
    assign w_load[info_index(k, 64'(FROZEN_MASK), N)] = in_msg[k];
  end
  polar_xor_stage #(.N(N), .LOG2N(LOG2N)) u_stage (
    .i_v_in (r_v),
    .i_stage(r_cnt),
    .o_v_out(w_stage)
  );
  always_comb begin
    w_next = r_state == IDLE ? (in_valid ? ENC : IDLE)
           : r_state == ENC  ? (r_cnt == LOG2N'(LOG2N - 1) ? OUT : ENC)
           : (out_ready ? IDLE : OUT);
    in_ready = rst_n && r_state == IDLE;
    out_valid = rst_n && r_state == OUT;
    busy = rst_n && r_state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_v <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_valid) begin
        r_v <= w_load;
        r_cnt <= '0;
      end else if (r_state == ENC) begin
        r_v <= w_stage;
        r_cnt <= r_cnt + LOG2N'(1);
      end
    end
  end
`ifdef POLAR_BITREV_EN
  for (genvar i = 0; i < N; i++) begin : g_rev
    assign out_code[i] = r_v[bitrev(i, LOG2N)];
  end
`else
  assign out_code = r_v;
`endif
endmodule

// File: tb/tb_polar_encoder_seq.sv
// tb_polar_encoder_seq: directed vectors with hand-computed codewords for the N=8, mask 8'h17 encoder.
module tb_polar_encoder_seq;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] in_msg;
  logic [7:0] out_code;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  polar_encoder_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .busy(busy)
  );
  logic [3:0] msgs[6] = '{4'b1111, 4'b0001, 4'b1000, 4'b0000, 4'b0010, 4'b0100};
`ifdef POLAR_BITREV_EN
  logic [7:0] exps[6] = '{8'h96, 8'h55, 8'hFF, 8'h00, 8'h33, 8'h0F};
`else
  logic [7:0] exps[6] = '{8'h96, 8'h0F, 8'hFF, 8'h00, 8'h33, 8'h55};
`endif
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [3:0] msg, input logic [7:0] exp);
    in_valid = 1'b1;
    in_msg = msg;
    out_ready = 1'b1;
    chk("idle_ready", {7'd0, in_ready}, 8'd1);
    tick();
    in_valid = 1'b0;
    chk("enc_busy", {7'd0, busy}, 8'd1);
    chk("enc_in_ready", {7'd0, in_ready}, 8'd0);
    tick();
    tick();
    chk("early_valid", {7'd0, out_valid}, 8'd0);
    tick();
    chk("out_valid", {7'd0, out_valid}, 8'd1);
    chk("out_code", out_code, exp);
    tick();
    chk("post_hs_valid", {7'd0, out_valid}, 8'd0);
    chk("post_hs_ready", {7'd0, in_ready}, 8'd1);
    chk("idle_hold", out_code, exp);
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_msg = '0;
    repeat (3) tick();
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_out_code", out_code, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", {7'd0, in_ready}, 8'd1);
    for (int v = 0; v < 6; v++) run(msgs[v], exps[v]);
    in_valid = 1'b1;
    in_msg = 4'b1111;
    out_ready = 1'b0;
    tick();
    in_msg = 4'b0001;
    repeat (3) tick();
    chk("bp_valid", {7'd0, out_valid}, 8'd1);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_code", out_code, 8'h96);
      chk("bp_in_ready", {7'd0, in_ready}, 8'd0);
      chk("bp_valid_hold", {7'd0, out_valid}, 8'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", {7'd0, in_ready}, 8'd1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("pend_valid", {7'd0, out_valid}, 8'd1);
    chk("pend_code", out_code, exps[1]);
    tick();
    in_valid = 1'b1;
    in_msg = 4'b1000;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_code", out_code, 8'h00);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("abort_no_valid", {7'd0, out_valid}, 8'd0);
    end
    run(4'b0001, exps[1]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/polar_encoder_seq.md
Name: polar_encoder_seq

Overview:
- Sequential polar encoder: the transmit-side counterpart of the team's polar decoder.
- Takes a K-bit message and places it into the non-frozen positions of a length-N vector u. It then computes x = u·G_N, with G_N = F^{⊗n} and F = [[1,0],[1,1]].
- Encoding runs one XOR-butterfly stage per clock, with a valid/ready handshake on each side.
- Generates reference codewords and feeds the decoder datapath in loopback tests.

Parameters:
- N, 8, code length; power of two, ≥2.
- LOG2N, 3, log2(N); number of butterfly stages.
- K, 4, message length; must equal the count of zeros in FROZEN_MASK. Elaboration error otherwise.
- FROZEN_MASK, 8'h17, N-bit mask; bit i=1 means u_i is frozen to 0. Default info set is {3,5,6,7}.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, message valid.
- in_ready, output, 1, encoder can accept a message.
- in_msg, input, K, message; bit 0 maps to the lowest non-frozen index.
- out_valid, output, 1, codeword valid.
- out_ready, input, 1, downstream accepts the codeword.
- out_code, output, N, codeword; bit i = x_i.
- busy, output, 1, high in ENC or OUT.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, stage counter=0, work register=0.
  - out_valid=0, out_code=0, in_ready=0 during reset, busy=0.
  - Reset mid-ENC or mid-OUT aborts the frame with no output.
- FSM states: IDLE, ENC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, load the work register v: v[i]=0 for frozen i; non-frozen indices filled ascending from in_msg[0].
  - Clear the stage counter; go to ENC.
- ENC:
  - in_ready=0.
  - Each cycle applies stage s = counter: for every i with bit s clear, v[i] ← v[i] ^ v[i+2^s]; v[i+2^s] is unchanged.
  - Counter increments; after stage LOG2N-1, go to OUT.
- OUT:
  - out_valid=1; out_code=v, held stable until the handshake.
  - On out_valid&out_ready, go to IDLE. in_ready is 0 throughout OUT.
- Latency: out_valid rises LOG2N clocks after the accepting edge (3 for N=8).
- Throughput: one frame per LOG2N+2 cycles when out_ready is held high.
- Backpressure: out_ready=0 holds OUT indefinitely; no data change and no overflow.
- in_valid while in ENC/OUT is ignored; the source must hold it until in_ready.
- out_code holds its last value in IDLE; it is not cleared.
- Arithmetic is GF(2) only; there is no width growth.

Optional Feature:
- Macro POLAR_BITREV_EN.
- Defined: out_code[i] = v[bitrev_LOG2N(i)], giving the bit-reversed-order codeword x = u·B_N·G_N, matching decoders that expect natural-order LLR input. Latency is unchanged; the permutation is pure wiring on the output.
- Undefined: out_code = v directly.

Decomposition:
- Shared package polar_pkg holds:
  - N, LOG2N, K, FROZEN_MASK defaults.
  - State enum {IDLE, ENC, OUT}.
  - Function bitrev(idx, LOG2N).
  - Function info_index(k) returning the k-th non-frozen position.
- Sub-module polar_xor_stage: combinational, with N-bit v_in, stage select [LOG2N-1:0] and N-bit v_out. It implements one butterfly stage selected at runtime. The top level keeps the FSM, counter and handshake.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles → out_valid=0, in_ready=0, busy=0, out_code=0. Release → in_ready=1 on the next cycle.
- Single frame: in_msg=4'b1111 accepted at edge E0, out_ready=1 → out_valid high after E3, out_code=8'h96, then in_ready=1 one cycle after the handshake.
- Unit vectors: in_msg=4'b0001 → 8'h0F; in_msg=4'b1000 → 8'hFF; in_msg=4'b0000 → 8'h00.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_code stays stable at 8'h96, in_ready=0, and a pending in_valid is not consumed.
- Reset mid-ENC: assert rst_n=0 at stage 1 → next cycle IDLE, out_valid never asserts for that frame, and the next frame 4'b0001 yields 8'h0F.
- With POLAR_BITREV_EN: in_msg=4'b0001 → out_code=8'h55; in_msg=4'b1111 → 8'h96 (permutation-invariant set).
